serial_ip_prec_slice: RTL and testbench

Bit-serial inner-product slice for one filter across TW windows, with an on-block precision controller. Neurons stream in MSB-first, one bit per lane per cycle. The pass length is a run-time precision P, and neurons may be signed or unsigned. The block sits between the neuron broadcast bus and NBout: it takes a partial sum, adds the filter contribution, saturates, applies optional max-pooling, and returns the result over a valid/ready handshake.

---
 rtl/stripes_pkg.sv | 44 ++++
 rtl/serial_ip_prec_slice_if.sv | 34 +++
 rtl/serial_ip_lane.sv | 99 +++++++++
 rtl/serial_ip_prec_slice.sv | 144 ++++++++++++++
 tb/tb_serial_ip_prec_slice.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stripes_pkg.sv
// Shared types, default sizing and arithmetic helpers for the bit-serial
// inner-product slice.
package stripes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int N_DEF         = 16;
   localparam int TI_DEF        = 16;
   localparam int TW_DEF        = 16;
   localparam int P_MAX_DEF     = 16;
   localparam int ACC_W_DEF     = 32;
   localparam int TREE_PIPE_DEF = 1;

   function automatic int tree_w(input int n, input int ti);
      return n + $clog2(ti);
   endfunction

   localparam int TREE_W = tree_w(N_DEF, TI_DEF);

   // Clip a wide signed value into the range of an n-bit two's complement word.
   function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                                input int unsigned n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

   function automatic logic signed [63:0] smax(input logic signed [63:0] a,
                                               input logic signed [63:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/serial_ip_prec_slice_if.sv
// Bus between the neuron broadcast / NBout side and the inner-product slice.
interface serial_ip_prec_slice_if
   import stripes_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int TI = TI_DEF,
   parameter int TW = TW_DEF
);
   logic              i_start;
   logic [4:0]        i_precision;
   logic              i_signed;
   logic              i_max;
   logic              i_syn_load;
   logic [TI*N-1:0]   i_synapses;
   logic [TW*N-1:0]   i_nbout;
   logic              i_neuron_valid;
   logic [TW*TI-1:0]  i_neurons;
   logic              o_ready;
   logic              o_valid;
   logic              i_out_ready;
   logic [TW*N-1:0]   o_result;

   modport slave (
      input  i_start, i_precision, i_signed, i_max, i_syn_load, i_synapses,
             i_nbout, i_neuron_valid, i_neurons, i_out_ready,
      output o_ready, o_valid, o_result
   );

   modport master (
      output i_start, i_precision, i_signed, i_max, i_syn_load, i_synapses,
             i_nbout, i_neuron_valid, i_neurons, i_out_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/serial_ip_lane.sv
// One window: gated/negated lane products, signed adder tree, shift-accumulate
// and the final saturate / max-pool stage.
module serial_ip_lane
   import stripes_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int TI        = TI_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int TREE_PIPE = TREE_PIPE_DEF,
   parameter int TW_L      = TREE_W
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic                 i_col_valid,
   input  logic                 i_negate,
   input  logic                 i_max,
   input  logic                 i_load_result,
   input  logic [TI*N-1:0]      i_synapses,
   input  logic [TI-1:0]        i_bits,
   input  logic signed [N-1:0]  i_nbout,
   output logic signed [N-1:0]  o_result
);

   logic signed [TW_L-1:0]  w_tree;
   logic                    w_tree_vld;
   logic signed [ACC_W-1:0] w_tree_ext;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [63:0]      w_sum64;
   logic signed [63:0]      w_nb64;
   logic signed [N-1:0]     w_s;
   logic signed [N-1:0]     w_fin;
   logic signed [N-1:0]     r_result;

   genvar gi;

   // Heap-ordered tree: node k sums nodes 2k+1 and 2k+2, leaves sit at TI-1..2TI-2.
   generate
      for (gi = 0; gi < 2*TI-1; gi++) begin : g_node
         logic signed [TW_L-1:0] w_sum;
         if (gi >= TI-1) begin : g_leaf
            localparam int LANE = gi - (TI - 1);
            logic signed [TW_L-1:0] w_syn;
            assign w_syn = {{(TW_L-N){i_synapses[LANE*N+N-1]}}, i_synapses[LANE*N +: N]};
            assign w_sum = !i_bits[LANE] ? '0 : (i_negate ? -w_syn : w_syn);
         end else begin : g_add
            assign w_sum = g_node[2*gi+1].w_sum + g_node[2*gi+2].w_sum;
         end
      end
   endgenerate

   // The pipe stage carries its own valid tag so a stalled column is never
   // accumulated twice or dropped.
   generate
      if (TREE_PIPE != 0) begin : g_pipe
         logic signed [TW_L-1:0] r_sum;
         logic                   r_vld;
         always_ff @(posedge clk) begin
            if (reset || i_clear) begin
               r_sum <= '0;
               r_vld <= 1'b0;
            end else begin
               r_vld <= i_col_valid;
               if (i_col_valid)
                  r_sum <= g_node[0].w_sum;
            end
         end
         assign w_tree     = r_sum;
         assign w_tree_vld = r_vld;
      end else begin : g_nopipe
         assign w_tree     = g_node[0].w_sum;
         assign w_tree_vld = i_col_valid;
      end
   endgenerate

   assign w_tree_ext = {{(ACC_W-TW_L){w_tree[TW_L-1]}}, w_tree};

   always_ff @(posedge clk) begin
      if (reset || i_clear)
         r_acc <= '0;
      else if (w_tree_vld)
         r_acc <= (r_acc <<< 1) + w_tree_ext;
   end

   assign w_nb64  = {{(64-N){i_nbout[N-1]}}, i_nbout};
   assign w_sum64 = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc} + w_nb64;
   assign w_s     = N'(sat_n(w_sum64, N));
   assign w_fin   = i_max ? N'(smax({{(64-N){w_s[N-1]}}, w_s}, w_nb64)) : w_s;

   always_ff @(posedge clk) begin
      if (reset)
         r_result <= '0;
      else if (i_load_result)
         r_result <= w_fin;
   end

   assign o_result = r_result;

endmodule

// File: rtl/serial_ip_prec_slice.sv
// Bit-serial inner-product slice: pass control, precision counter, synapse
// register and TW window lanes.
module serial_ip_prec_slice
   import stripes_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int TI        = TI_DEF,
   parameter int TW        = TW_DEF,
   parameter int P_MAX     = P_MAX_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int TREE_PIPE = TREE_PIPE_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   serial_ip_prec_slice_if.slave bus
);

   state_t           r_state;
   state_t           w_state_next;
   logic [4:0]       r_cnt;
   logic [4:0]       r_prec;
   logic             r_signed;
   logic             r_max;
   logic             r_drain;
   logic [TW*N-1:0]  r_nbout;
   logic [TI*N-1:0]  r_syn;
   logic [TW*N-1:0]  w_result;
   logic [4:0]       w_prec_eff;
   logic             w_ready;
   logic             w_valid;
   logic             w_accept;
   logic             w_col;
   logic             w_syn_we;
   logic             w_last_col;
   logic             w_negate;
   logic             w_drain_done;

   assign w_prec_eff = (bus.i_precision == 5'd0)      ? 5'd1 :
                       (bus.i_precision > 5'(P_MAX))  ? 5'(P_MAX) :
                                                        bus.i_precision;

   assign w_last_col   = w_col && (r_cnt == 5'd1);
   // The counter still equals P only while the MSB column is on the bus.
   assign w_negate     = r_signed && (r_cnt == r_prec);
   assign w_drain_done = (r_state == ST_DRAIN) && (r_drain == 1'(TREE_PIPE));

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (bus.i_start)     w_state_next = ST_RUN;
         ST_RUN:   if (w_last_col)      w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_drain_done)    w_state_next = ST_DONE;
         ST_DONE:  if (bus.i_out_ready) w_state_next = ST_IDLE;
         default:                       w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready  = 1'b0;
      w_valid  = 1'b0;
      w_accept = 1'b0;
      w_col    = 1'b0;
      w_syn_we = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready  = 1'b1;
            w_accept = bus.i_start;
            w_syn_we = bus.i_syn_load;
         end
         ST_RUN: w_col = bus.i_neuron_valid;
         ST_DONE: begin
            w_valid  = 1'b1;
            w_syn_we = bus.i_syn_load;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_prec   <= '0;
         r_signed <= 1'b0;
         r_max    <= 1'b0;
         r_nbout  <= '0;
         r_drain  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= w_prec_eff;
            r_prec   <= w_prec_eff;
            r_signed <= bus.i_signed;
            r_max    <= bus.i_max;
            r_nbout  <= bus.i_nbout;
         end else if (w_col) begin
            r_cnt <= r_cnt - 5'd1;
         end
         r_drain <= (r_state == ST_DRAIN) ? r_drain + 1'b1 : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_syn <= '0;
      else if (w_syn_we)
         r_syn <= bus.i_synapses;
   end

   genvar gi;
   generate
      for (gi = 0; gi < TW; gi++) begin : g_lane
         serial_ip_lane #(
            .N         (N),
            .TI        (TI),
            .ACC_W     (ACC_W),
            .TREE_PIPE (TREE_PIPE),
            .TW_L      (tree_w(N, TI))
         ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .i_clear       (w_accept),
            .i_col_valid   (w_col),
            .i_negate      (w_negate),
            .i_max         (r_max),
            .i_load_result (w_drain_done),
            .i_synapses    (r_syn),
            .i_bits        (bus.i_neurons[gi*TI +: TI]),
            .i_nbout       (r_nbout[gi*N +: N]),
            .o_result      (w_result[gi*N +: N])
         );
      end
   endgenerate

   assign bus.o_ready  = w_ready;
   assign bus.o_valid  = w_valid;
   assign bus.o_result = w_result;

endmodule

// File: tb/tb_serial_ip_prec_slice.sv
// Directed and randomized passes against an arithmetic inner-product model.
module tb_serial_ip_prec_slice;
   import stripes_pkg::*;

   localparam int N         = 16;
   localparam int TI        = 16;
   localparam int TW        = 16;
   localparam int P_MAX     = 16;
   localparam int ACC_W     = 32;
   localparam int TREE_PIPE = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_ip_prec_slice_if #(.N(N), .TI(TI), .TW(TW)) bus();

   serial_ip_prec_slice #(
      .N(N), .TI(TI), .TW(TW), .P_MAX(P_MAX), .ACC_W(ACC_W), .TREE_PIPE(TREE_PIPE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   int     syn [TI];
   int     nb  [TW];
   longint nv  [TW][TI];
   longint exp_res [TW];

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inner product of synapses with P-bit neuron values, then saturate and pool.
   function automatic longint model(input int w, input int pe, input bit sgn, input bit mx);
      longint acc = 0;
      longint v;
      longint lim = longint'(1) << (N - 1);
      for (int i = 0; i < TI; i++) begin
         v = nv[w][i] & ((longint'(1) << pe) - 1);
         if (sgn && v >= (longint'(1) << (pe - 1)))
            v = v - (longint'(1) << pe);
         acc += longint'(syn[i]) * v;
      end
      acc += longint'(nb[w]);
      if (acc > lim - 1)
         acc = lim - 1;
      else if (acc < -lim)
         acc = -lim;
      if (mx && longint'(nb[w]) > acc)
         acc = longint'(nb[w]);
      return acc;
   endfunction

   task automatic load_syn();
      bus.i_syn_load = 1'b1;
      for (int i = 0; i < TI; i++)
         bus.i_synapses[i*N +: N] = N'(syn[i]);
      tick();
      bus.i_syn_load = 1'b0;
   endtask

   task automatic scramble_neurons();
      for (int b = 0; b < TW*TI; b++)
         bus.i_neurons[b] = 1'($urandom_range(0, 1));
   endtask

   task automatic run_pass(input int p, input bit sgn, input bit mx, input int stall_at,
                           input int stall_len, input int hold, input bit intrude);
      int pe;
      int n;
      logic [TW*N-1:0] exp_vec;
      pe = (p == 0) ? 1 : ((p > P_MAX) ? P_MAX : p);
      for (int w = 0; w < TW; w++) begin
         exp_res[w] = model(w, pe, sgn, mx);
         exp_vec[w*N +: N] = N'(exp_res[w]);
      end
      check_eq("ready_idle", longint'(bus.o_ready), 1);
      bus.i_start     = 1'b1;
      bus.i_precision = 5'(p);
      bus.i_signed    = sgn;
      bus.i_max       = mx;
      for (int w = 0; w < TW; w++)
         bus.i_nbout[w*N +: N] = N'(nb[w]);
      tick();
      bus.i_start     = 1'b0;
      bus.i_precision = 5'($urandom);
      bus.i_signed    = 1'($urandom);
      bus.i_max       = 1'($urandom);
      for (int w = 0; w < TW; w++)
         bus.i_nbout[w*N +: N] = N'($urandom);
      check_eq("ready_run", longint'(bus.o_ready), 0);
      for (int k = 0; k < pe; k++) begin
         if (k == stall_at) begin
            bus.i_neuron_valid = 1'b0;
            scramble_neurons();
            repeat (stall_len) tick();
         end
         if (intrude && k == 1) begin
            bus.i_start    = 1'b1;
            bus.i_syn_load = 1'b1;
            for (int i = 0; i < TI; i++)
               bus.i_synapses[i*N +: N] = N'($urandom);
         end
         for (int w = 0; w < TW; w++)
            for (int i = 0; i < TI; i++)
               bus.i_neurons[w*TI+i] = 1'((nv[w][i] >> (pe - 1 - k)) & 1);
         bus.i_neuron_valid = 1'b1;
         tick();
         bus.i_start    = 1'b0;
         bus.i_syn_load = 1'b0;
      end
      bus.i_neuron_valid = 1'b0;
      scramble_neurons();
      check_eq("valid_early", longint'(bus.o_valid), 0);
      n = 0;
      while (!bus.o_valid && n < 12) begin
         tick();
         n++;
      end
      check_eq("latency", n, TREE_PIPE + 1);
      for (int w = 0; w < TW; w++)
         check_eq($sformatf("result_w%0d", w), longint'($signed(bus.o_result[w*N +: N])), exp_res[w]);
      if (hold > 0) begin
         bus.i_out_ready = 1'b0;
         repeat (hold) begin
            tick();
            check_eq("hold_valid", longint'(bus.o_valid), 1);
            check_eq("hold_ready", longint'(bus.o_ready), 0);
            check_eq("hold_result", longint'(bus.o_result == exp_vec), 1);
         end
         bus.i_out_ready = 1'b1;
      end
      tick();
      check_eq("back_idle_valid", longint'(bus.o_valid), 0);
      check_eq("back_idle_ready", longint'(bus.o_ready), 1);
   endtask

   task automatic rand_data(input int pe, input bit small_syn);
      for (int i = 0; i < TI; i++)
         syn[i] = small_syn ? int'($urandom_range(0, 15)) - 8 : int'($urandom_range(0, 65535)) - 32768;
      for (int w = 0; w < TW; w++) begin
         nb[w] = int'($urandom_range(0, 65535)) - 32768;
         for (int i = 0; i < TI; i++)
            nv[w][i] = longint'($urandom) & ((longint'(1) << pe) - 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int p;
      reset              = 1'b1;
      bus.i_start        = 1'b0;
      bus.i_precision    = '0;
      bus.i_signed       = 1'b0;
      bus.i_max          = 1'b0;
      bus.i_syn_load     = 1'b0;
      bus.i_synapses     = '0;
      bus.i_nbout        = '0;
      bus.i_neuron_valid = 1'b0;
      bus.i_neurons      = '0;
      bus.i_out_ready    = 1'b1;
      repeat (3) tick();
      check_eq("rst_ready", longint'(bus.o_ready), 1);
      check_eq("rst_valid", longint'(bus.o_valid), 0);
      check_eq("rst_result_nz", longint'(|bus.o_result), 0);
      reset = 1'b0;
      tick();

      // All ones, single column
      for (int i = 0; i < TI; i++) syn[i] = 1;
      for (int w = 0; w < TW; w++) begin
         nb[w] = 0;
         for (int i = 0; i < TI; i++) nv[w][i] = 1;
      end
      load_syn();
      run_pass(1, 1'b0, 1'b0, -1, 0, 0, 1'b0);

      // Lane 0 only: 1101 times 5 plus 7, signed then unsigned
      for (int i = 0; i < TI; i++) syn[i] = (i == 0) ? 5 : 0;
      for (int w = 0; w < TW; w++) begin
         nb[w] = 7;
         for (int i = 0; i < TI; i++) nv[w][i] = (i == 0) ? 13 : longint'($urandom_range(0, 15));
      end
      load_syn();
      run_pass(4, 1'b1, 1'b0, -1, 0, 0, 1'b0);
      run_pass(4, 1'b0, 1'b0, -1, 0, 0, 1'b0);

      // Saturation both ways
      for (int i = 0; i < TI; i++) syn[i] = 32767;
      for (int w = 0; w < TW; w++) begin
         nb[w] = 0;
         for (int i = 0; i < TI; i++) nv[w][i] = 255;
      end
      load_syn();
      run_pass(8, 1'b0, 1'b0, -1, 0, 0, 1'b0);
      for (int i = 0; i < TI; i++) syn[i] = -32768;
      load_syn();
      run_pass(8, 1'b0, 1'b0, -1, 0, 0, 1'b0);

      // Max pooling: s = 10 below and above nbout
      for (int i = 0; i < TI; i++) syn[i] = (i == 0) ? -10 : 0;
      for (int w = 0; w < TW; w++) begin
         nb[w] = 20;
         for (int i = 0; i < TI; i++) nv[w][i] = 1;
      end
      load_syn();
      run_pass(1, 1'b0, 1'b1, -1, 0, 0, 1'b0);
      syn[0] = 15;
      for (int w = 0; w < TW; w++) nb[w] = -5;
      load_syn();
      run_pass(1, 1'b0, 1'b1, -1, 0, 0, 1'b0);

      // Stall mid-pass, then hold the result
      rand_data(8, 1'b0);
      load_syn();
      run_pass(8, 1'b1, 1'b0, -1, 0, 0, 1'b0);
      run_pass(8, 1'b1, 1'b0, 4, 3, 5, 1'b0);

      // Start / synapse load ignored while running
      rand_data(6, 1'b0);
      load_syn();
      run_pass(6, 1'b0, 1'b0, -1, 0, 0, 1'b1);

      // Precision clamps
      rand_data(1, 1'b0);
      load_syn();
      run_pass(0, 1'b1, 1'b0, -1, 0, 0, 1'b0);
      rand_data(16, 1'b1);
      load_syn();
      run_pass(20, 1'b1, 1'b1, 2, 2, 1, 1'b0);

      // Reset in the middle of a pass
      bus.i_start     = 1'b1;
      bus.i_precision = 5'd8;
      tick();
      bus.i_start        = 1'b0;
      bus.i_neuron_valid = 1'b1;
      scramble_neurons();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset              = 1'b0;
      bus.i_neuron_valid = 1'b0;
      check_eq("mid_rst_valid", longint'(bus.o_valid), 0);
      check_eq("mid_rst_ready", longint'(bus.o_ready), 1);
      check_eq("mid_rst_result_nz", longint'(|bus.o_result), 0);

      // Synapses were cleared by reset, so the result is just nbout
      rand_data(5, 1'b0);
      for (int i = 0; i < TI; i++) syn[i] = 0;
      run_pass(5, 1'b1, 1'b0, -1, 0, 0, 1'b0);
      rand_data(5, 1'b0);
      load_syn();
      run_pass(5, 1'b1, 1'b0, -1, 0, 0, 1'b0);

      for (int r = 0; r < 12; r++) begin
         p = int'($urandom_range(1, 11));
         rand_data(p, 1'b0);
         load_syn();
         run_pass(p, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, p - 1)) : -1,
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
